// File: rtl/acc_core_sequencer.sv
// acc_core_sequencer
//   Multi-cycle fetch/decode/execute sequencer for the accumulator machine.
//   Owns PC, MAR, MBR, IR and ACC and talks to a single shared memory port
//   through a req/ack handshake that tolerates any number of wait states.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   run        start execution (sampled only in IDLE)
//   mem_req    memory request, held until mem_ack
//   mem_we     1 = write, 0 = read (valid while mem_req)
//   mem_addr   request address (MAR)
//   mem_wdata  write data (MBR)
//   mem_rdata  read data, valid while mem_ack = 1
//   mem_ack    completes the current request
//   halted     1 in HALT
//   illegal    sticky illegal-opcode flag
//   acc_out    accumulator
//   pc_out     program counter
//
// Build option
//   ACC_CORE_TRAP_ILLEGAL_EN : opcode E traps (illegal=1, HALT).
//                              Undefined: opcode E executes as NOP, illegal=0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for run
// FETCH    | read instruction at MAR (=PC) into IR, advance PC
// DECODE   | latch operand address into MAR, pick next state
// OPERAND  | read M[MAR] into MBR
// STORE    | write MBR (=ACC) to M[MAR]
// EXECUTE  | update ACC / PC, point MAR at next PC
// HALT     | frozen until reset

module acc_core_sequencer #(
  parameter int DATA_W   = 16,
  parameter int OPC_W    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      run,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [DATA_W-OPC_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ack,
  output logic                      halted,
  output logic                      illegal,
  output logic [DATA_W-1:0]         acc_out,
  output logic [DATA_W-OPC_W-1:0]   pc_out
);

  localparam int ADDR_W = DATA_W - OPC_W;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_SHL   = 4'h8;
  localparam logic [3:0] OP_SHR   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_JN    = 4'hC;
  localparam logic [3:0] OP_LOADI = 4'hD;
  localparam logic [3:0] OP_RSVD  = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPERAND, S_STORE, S_EXECUTE, S_HALT
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] pc, mar, pc_next;
  logic [DATA_W-1:0] acc, mbr, ir, acc_next;
  logic [OPC_W-1:0]  opc;
  logic [ADDR_W-1:0] addr_f;

  assign opc    = ir[DATA_W-1 -: OPC_W];
  assign addr_f = ir[ADDR_W-1:0];

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (run) next_state = S_FETCH;
      S_FETCH:   if (mem_ack) next_state = S_DECODE;
      S_DECODE: begin
        case (opc)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: next_state = S_OPERAND;
          OP_STORE: next_state = S_STORE;
          OP_HALT:  next_state = S_HALT;
`ifdef ACC_CORE_TRAP_ILLEGAL_EN
          OP_RSVD:  next_state = S_HALT;
`else
          OP_RSVD:  next_state = S_EXECUTE;
`endif
          default:  next_state = S_EXECUTE;
        endcase
      end
      S_OPERAND: if (mem_ack) next_state = S_EXECUTE;
      S_STORE:   if (mem_ack) next_state = S_FETCH;
      S_EXECUTE: next_state = S_FETCH;
      S_HALT:    next_state = S_HALT;
      default:   next_state = S_IDLE;
    endcase
  end

  // Outputs; the request is squashed combinationally while reset is high
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    halted  = 1'b0;
    case (state)
      S_FETCH, S_OPERAND: mem_req = ~reset;
      S_STORE: begin
        mem_req = ~reset;
        mem_we  = ~reset;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // Execute-stage ALU and branch resolution
  always_comb begin
    acc_next = acc;
    pc_next  = pc;
    case (opc)
      OP_LOAD:  acc_next = mbr;
      OP_ADD:   acc_next = acc + mbr;
      OP_SUB:   acc_next = acc - mbr;
      OP_AND:   acc_next = acc & mbr;
      OP_OR:    acc_next = acc | mbr;
      OP_XOR:   acc_next = acc ^ mbr;
      OP_SHL:   acc_next = {acc[DATA_W-2:0], 1'b0};
      OP_SHR:   acc_next = {1'b0, acc[DATA_W-1:1]};
      OP_JMP:   pc_next  = addr_f;
      OP_JZ:    if (acc == '0) pc_next = addr_f;
      OP_JN:    if (acc[DATA_W-1]) pc_next = addr_f;
      OP_LOADI: acc_next = {{OPC_W{1'b0}}, addr_f};
      OP_NOP, OP_STORE, OP_RSVD, OP_HALT: ;
      default:  ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pc  <= RESET_PC[ADDR_W-1:0];
      mar <= '0;
      mbr <= '0;
      ir  <= '0;
      acc <= '0;
    end else begin
      case (state)
        S_IDLE:    if (run) mar <= pc;
        S_FETCH: begin
          if (mem_ack) begin
            ir <= mem_rdata;
            pc <= pc + ADDR_W'(1);
          end
        end
        S_DECODE: begin
          mar <= addr_f;
          if (opc == OP_STORE) mbr <= acc;
        end
        S_OPERAND: if (mem_ack) mbr <= mem_rdata;
        S_STORE:   if (mem_ack) mar <= pc;
        S_EXECUTE: begin
          acc <= acc_next;
          pc  <= pc_next;
          mar <= pc_next;
        end
        default: ;
      endcase
    end
  end

`ifdef ACC_CORE_TRAP_ILLEGAL_EN
  logic illegal_q;
  always_ff @(posedge clock) begin
    if (reset) illegal_q <= 1'b0;
    else if (state == S_DECODE && opc == OP_RSVD) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign mem_addr  = mar;
  assign mem_wdata = mbr;
  assign acc_out   = acc;
  assign pc_out    = pc;

endmodule

// File: tb/tb_acc_core_sequencer.sv
// Testbench for acc_core_sequencer: memory model with programmable wait
// states, a table of single-instruction programs, and hand-written
// sequences for latency, PC wrap, HALT and reset-during-request.
module tb_acc_core_sequencer;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;

`ifdef ACC_CORE_TRAP_ILLEGAL_EN
  localparam logic [11:0] E_PC  = 12'h002;
  localparam logic        E_ILL = 1'b1;
`else
  localparam logic [11:0] E_PC  = 12'h003;
  localparam logic        E_ILL = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [15:0] acc0;
    logic [15:0] instr;
    logic [15:0] mval;
    logic [15:0] exp_acc;
    logic [15:0] exp_m;
    logic [11:0] exp_pc;
    logic        exp_ill;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic mem_req, mem_we, halted, illegal;
  logic mem_ack = 1'b0;
  logic [ADDR_W-1:0] mem_addr, pc_out;
  logic [DATA_W-1:0] mem_wdata, acc_out;
  logic [DATA_W-1:0] mem_rdata = '0;

  logic [15:0] mem [0:4095];
  bit          auto_mem = 1'b1;
  logic        man_ack = 1'b0;
  logic [15:0] man_rdata = '0;
  int          wait_n = 0;
  int          wait_cnt = 0;

  bit          prev_wait = 1'b0;
  logic [11:0] prev_addr;
  logic        prev_we;
  logic [15:0] prev_wdata;
  int          stab_checks = 0;
  int          stab_viol = 0;

  int vec_cnt = 0;
  int err_cnt = 0;

  acc_core_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .halted    (halted),
    .illegal   (illegal),
    .acc_out   (acc_out),
    .pc_out    (pc_out)
  );

  always #5 clock = ~clock;

  // Memory responder: decides ack/rdata at the falling edge, performs the
  // write there too, and watches that request fields hold while waiting.
  always @(negedge clock) begin
    if (prev_wait && mem_req) begin
      stab_checks++;
      if (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata)
        stab_viol++;
    end
    if (auto_mem) begin
      if (mem_req) begin
        if (wait_cnt >= wait_n) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          if (mem_we) mem[mem_addr] = mem_wdata;
          wait_cnt  = 0;
        end else begin
          mem_ack  = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end else begin
      mem_ack   = man_ack;
      mem_rdata = man_rdata;
    end
    prev_wait  = mem_req && !mem_ack;
    prev_addr  = mem_addr;
    prev_we    = mem_we;
    prev_wdata = mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'hF000;
  endtask

  // Release reset, pulse run, count edges until halted (bounded).
  task automatic run_prog(input string name, input int limit, output int cycles);
    reset = 1'b0;
    run   = 1'b1;
    @(posedge clock);
    #1;
    run    = 1'b0;
    cycles = 0;
    while (!halted && cycles < limit) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    check({name, "_halt_reached"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic load_demo();
    clear_mem();
    mem[12'h000] = 16'hD005;
    mem[12'h001] = 16'h300A;
    mem[12'h002] = 16'h200B;
    mem[12'h003] = 16'hF000;
    mem[12'h00A] = 16'h0007;
    mem[12'h00B] = 16'h0000;
  endtask

  initial begin
    vec_t vt [17];
    int   cyc;
    bit   req_seen;

    vt[0]  = '{"nop",    16'h1234, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 12'h003, 1'b0};
    vt[1]  = '{"load",   16'h0000, 16'h1030, 16'hABCD, 16'hABCD, 16'hABCD, 12'h003, 1'b0};
    vt[2]  = '{"add",    16'hFFFF, 16'h3030, 16'h0002, 16'h0001, 16'h0002, 12'h003, 1'b0};
    vt[3]  = '{"sub",    16'h0001, 16'h4030, 16'h0002, 16'hFFFF, 16'h0002, 12'h003, 1'b0};
    vt[4]  = '{"and",    16'hF0F0, 16'h5030, 16'h3C3C, 16'h3030, 16'h3C3C, 12'h003, 1'b0};
    vt[5]  = '{"or",     16'hF0F0, 16'h6030, 16'h0F01, 16'hFFF1, 16'h0F01, 12'h003, 1'b0};
    vt[6]  = '{"xor",    16'hFF00, 16'h7030, 16'h0FF0, 16'hF0F0, 16'h0FF0, 12'h003, 1'b0};
    vt[7]  = '{"shl",    16'h8001, 16'h8000, 16'h0000, 16'h0002, 16'h0000, 12'h003, 1'b0};
    vt[8]  = '{"shr",    16'h8001, 16'h9000, 16'h0000, 16'h4000, 16'h0000, 12'h003, 1'b0};
    vt[9]  = '{"jmp",    16'h1111, 16'hA005, 16'h0000, 16'h1111, 16'h0000, 12'h006, 1'b0};
    vt[10] = '{"jz_tak", 16'h0000, 16'hB005, 16'h0000, 16'h0000, 16'h0000, 12'h006, 1'b0};
    vt[11] = '{"jz_not", 16'h0001, 16'hB005, 16'h0000, 16'h0001, 16'h0000, 12'h003, 1'b0};
    vt[12] = '{"jn_tak", 16'h8000, 16'hC006, 16'h0000, 16'h8000, 16'h0000, 12'h007, 1'b0};
    vt[13] = '{"jn_not", 16'h7FFF, 16'hC006, 16'h0000, 16'h7FFF, 16'h0000, 12'h003, 1'b0};
    vt[14] = '{"loadi",  16'hFFFF, 16'hD123, 16'h0000, 16'h0123, 16'h0000, 12'h003, 1'b0};
    vt[15] = '{"store",  16'h5A5A, 16'h2030, 16'h0000, 16'h5A5A, 16'h5A5A, 12'h003, 1'b0};
    vt[16] = '{"rsvd_e", 16'h00AA, 16'hE000, 16'h0000, 16'h00AA, 16'h0000, E_PC,    E_ILL};

    // Reset state
    clear_mem();
    do_reset();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_halted",  {31'd0, halted},  32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_acc",     {16'd0, acc_out}, 32'd0);
    check("rst_pc",      {20'd0, pc_out},  32'd0);

    // Table: LOAD preloads ACC from M[20], then the instruction under test
    for (int i = 0; i < 17; i++) begin
      do_reset();
      clear_mem();
      mem[12'h000] = 16'h1020;
      mem[12'h001] = vt[i].instr;
      mem[12'h020] = vt[i].acc0;
      mem[12'h030] = vt[i].mval;
      wait_n = i % 3;
      run_prog(vt[i].name, 400, cyc);
      check({vt[i].name, "_acc"}, {16'd0, acc_out}, {16'd0, vt[i].exp_acc});
      check({vt[i].name, "_pc"},  {20'd0, pc_out},  {20'd0, vt[i].exp_pc});
      check({vt[i].name, "_ill"}, {31'd0, illegal}, {31'd0, vt[i].exp_ill});
      check({vt[i].name, "_m30"}, {16'd0, mem[12'h030]}, {16'd0, vt[i].exp_m});
    end

    // Demo program, zero-wait memory: 3+4+3+2 cycles
    wait_n = 0;
    do_reset();
    load_demo();
    run_prog("demo0", 200, cyc);
    check("demo0_cycles", cyc, 32'd12);
    check("demo0_mB",     {16'd0, mem[12'h00B]}, 32'h000C);
    check("demo0_acc",    {16'd0, acc_out}, 32'h000C);
    check("demo0_pc",     {20'd0, pc_out},  32'h004);

    // HALT ignores run and issues no requests
    run = 1'b1;
    req_seen = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (mem_req) req_seen = 1'b1;
    end
    run = 1'b0;
    check("halt_run_ignored", {31'd0, halted}, 32'd1);
    check("halt_no_req",      {31'd0, req_seen}, 32'd0);
    check("halt_pc_frozen",   {20'd0, pc_out}, 32'h004);

    // Same program with 3 wait cycles per request (6 requests)
    wait_n = 3;
    do_reset();
    load_demo();
    run_prog("demo3", 400, cyc);
    check("demo3_cycles", cyc, 32'd30);
    check("demo3_mB",     {16'd0, mem[12'h00B]}, 32'h000C);
    check("demo3_acc",    {16'd0, acc_out}, 32'h000C);
    check("demo3_pc",     {20'd0, pc_out},  32'h004);
    check("stab_seen",    {31'd0, (stab_checks > 0)}, 32'd1);
    check("stab_viol",    stab_viol, 32'd0);

    // PC wrap: JZ 3 / LOADI 1 / JMP FFF / NOP@FFF wraps to 0 / JZ falls / HALT@1
    wait_n = 0;
    do_reset();
    clear_mem();
    mem[12'h000] = 16'hB003;
    mem[12'h003] = 16'hD001;
    mem[12'h004] = 16'hAFFF;
    mem[12'hFFF] = 16'h0000;
    run_prog("wrap", 200, cyc);
    check("wrap_cycles", cyc, 32'd17);
    check("wrap_acc",    {16'd0, acc_out}, 32'h0001);
    check("wrap_pc",     {20'd0, pc_out},  32'h002);

    // Reset during OPERAND with a same-cycle ack
    auto_mem = 1'b0;
    man_ack  = 1'b0;
    do_reset();
    reset = 1'b0;
    run   = 1'b1;
    @(posedge clock); #1;
    run = 1'b0;
    man_rdata = 16'hD077; man_ack = 1'b1;
    @(posedge clock); #1;
    man_ack = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("rmr_acc_pre", {16'd0, acc_out}, 32'h0077);
    man_rdata = 16'h1030; man_ack = 1'b1;
    @(posedge clock); #1;
    man_ack = 1'b0;
    @(posedge clock); #1;
    check("rmr_operand_req",  {31'd0, mem_req}, 32'd1);
    check("rmr_operand_addr", {20'd0, mem_addr}, 32'h030);
    man_rdata = 16'hFFFF; man_ack = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rmr_req_forced", {31'd0, mem_req}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    man_ack = 1'b0;
    #1;
    check("rmr_req_idle", {31'd0, mem_req}, 32'd0);
    check("rmr_mbr",      {16'd0, mem_wdata}, 32'h0000);
    check("rmr_acc",      {16'd0, acc_out}, 32'h0000);
    check("rmr_pc",       {20'd0, pc_out}, 32'h000);
    @(posedge clock); #1;
    check("rmr_stay_idle", {31'd0, mem_req}, 32'd0);
    check("rmr_not_halt",  {31'd0, halted}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
